fp_add_scheduler: RTL and testbench
===================================

# fp_add_scheduler

Round-robin scheduler that shares one combinational IEEE-754 single-precision adder between `N` requesters. Accepts one operand pair per transaction over a valid/ready handshake and holds the adder inputs stable for a fixed settle time. Captures the sum and overflow/underflow flags into registers and returns them with the requester ID over a second valid/ready handshake. Sits between the issuing units and the `adder_floating_point` instance.

## Interface
- `N`, 2 — number of requesters (2..8)
- `ADD_LAT`, 2 — cycles the adder inputs are held before the result is sampled (1..15)
- `IDW`, `$clog2(N)` — requester ID width
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `req_valid` in N — per-requester request valid
- `req_ready` out N — per-requester accept, at most one bit set
- `req_a` in N*32 — operand A, requester i at bits [32i+31:32i]
- `req_b` in N*32 — operand B, same packing as `req_a`
- `add_a` out 32 — operand A to shared adder
- `add_b` out 32 — operand B to shared adder
- `add_sum` in 32 — adder `final_sum`
- `add_ovf` in 1 — adder overflow flag
- `add_unf` in 1 — adder underflow flag
- `rsp_valid` out 1 — response valid
- `rsp_ready` in 1 — response accept
- `rsp_id` out IDW — index of the requester that issued the transaction
- `rsp_sum` out 32 — registered sum
- `rsp_ovf` out 1 — registered overflow flag
- `rsp_unf` out 1 — registered underflow flag
- `busy` out 1 — high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner = first `i` with `req_valid[i]`, searching from `ptr` upward with wrap-around.
  - `req_ready[winner]`=1 combinationally; every other `req_ready` bit is 0.
  - No valid request: all `req_ready`=0; stay in IDLE.
  - On handshake: latch `req_a`/`req_b` of the winner into `add_a`/`add_b`, latch winner into `rsp_id`, load `cnt`=ADD_LAT-1, go to WAIT.
- WAIT:
  - `req_ready`=0.
  - `add_a`/`add_b` hold their values.
  - `cnt` decrements each cycle.
  - At `cnt`==0: register `add_sum`, `add_ovf`, `add_unf` into the rsp registers; set `rsp_valid`=1; go to RESP.
- RESP:
  - `rsp_*` are held stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_valid`&`rsp_ready`: clear `rsp_valid`, set `ptr`=(`rsp_id`+1) mod N, return to IDLE.
- `add_a`/`add_b` keep their last values while in IDLE; there is no glitching between transactions.
- A requester dropping `req_valid` without a handshake is legal; arbitration re-evaluates every IDLE cycle.

## Timing
- Reset values: `req_ready`=0, `add_a`=0, `add_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_ovf`=0, `rsp_unf`=0, `busy`=0, `ptr`=0, state IDLE.
- Latency: handshake at edge k → `rsp_valid` high after edge k+ADD_LAT.
- Earliest next accept is the cycle after the response handshake. Throughput is 1 per ADD_LAT+2 cycles with `rsp_ready` held high.
- Simultaneous requests: granted in round-robin order starting at `ptr`. After reset `ptr`=0, so requester 0 wins first.
- Reset asserted mid-WAIT or mid-RESP: the transaction is discarded and all registers return to reset values immediately; no response is produced.

## Configuration
- `FP_SCHED_ZERO_BYPASS_EN`:
  - Defined: at acceptance, operands with bits [30:0]==0 are detected as ±0.
    - A zero → result is B. Otherwise B zero → result is A. Both zero → result is B.
    - Flags are 0 for any bypassed transaction.
    - The FSM goes directly from IDLE to RESP, so `rsp_valid` is high after edge k+1.
    - `add_a`/`add_b` are still loaded with the operands.
  - Not defined: every transaction goes through the adder and WAIT, including zero operands.

## Test plan
- Single op, N=2, ADD_LAT=2: req0 A=0x3F800000 (1.0), B=0x40000000 (2.0); adder returns 0x40400000 → `rsp_valid` after 2 edges, `rsp_sum`=0x40400000, `rsp_id`=0, flags 0.
- Contention: both `req_valid` high from reset → req0 is served, then req1, then req0 again; the `rsp_id` sequence is 0,1,0.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready`=0, `busy`=1 throughout; completes on the cycle `rsp_ready` rises.
- Reset mid-WAIT: deassert `rst_n` one cycle after the handshake → all outputs return to reset values; no `rsp_valid` pulse after release.
- Flag capture: adder drives `add_ovf`=1 with sum 0x7F800000 → `rsp_ovf`=1, `rsp_unf`=0.
- Zero bypass (macro defined): A=0x80000000, B=0x40A00000 → `rsp_sum`=0x40A00000 after 1 edge, flags 0. Without the macro, the same stimulus takes ADD_LAT cycles and returns `add_sum`.

Source files
------------

// File: rtl/fp_add_scheduler_if.sv
// fp_add_scheduler_if: request/response bundle between the issuing units and the
// shared-adder scheduler.
//   req_valid/req_ready : per-requester handshake, req_ready is one-hot or zero
//   req_a/req_b         : packed operands, requester i at bits [32i+31:32i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_sum/rsp_ovf/rsp_unf : response payload
// Modports: master = issuing side, slave = scheduler.
interface fp_add_scheduler_if #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = $clog2(N)
) ();
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_sum;
  logic            rsp_ovf;
  logic            rsp_unf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_unf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_unf
  );
endinterface

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin scheduler sharing one combinational single-precision
// adder between N requesters. One operand pair is accepted per transaction, held on
// the adder inputs for ADD_LAT cycles, and the sampled sum/flags are returned with the
// requester index.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   io_bus             : request/response bundle (fp_add_scheduler_if.slave)
//   o_add_a, o_add_b   : operands to the shared adder
//   i_add_sum          : adder result
//   i_add_ovf/i_add_unf: adder overflow/underflow flags
//   o_busy             : high whenever a transaction is in flight
// Optional feature: define FP_SCHED_ZERO_BYPASS_EN to answer transactions with a +/-0
// operand directly from the other operand, skipping the adder wait.
module fp_add_scheduler #(
  parameter int unsigned N       = 2,
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned IDW     = $clog2(N)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  fp_add_scheduler_if.slave        io_bus,
  output logic [31:0]              o_add_a,
  output logic [31:0]              o_add_b,
  input  logic [31:0]              i_add_sum,
  input  logic                     i_add_ovf,
  input  logic                     i_add_unf,
  output logic                     o_busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         r_state, w_state_d;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_rsp_id;
  logic [3:0]     r_cnt;
  logic [31:0]    r_add_a, r_add_b;
  logic [31:0]    r_rsp_sum;
  logic           r_rsp_valid, r_rsp_ovf, r_rsp_unf;

  logic [31:0]    w_a_arr [N];
  logic [31:0]    w_b_arr [N];
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic [31:0]    w_sel_a, w_sel_b;
  logic [N-1:0]   w_req_ready;
  logic           w_accept;
  logic           w_rsp_done;
  logic           w_bypass;
  logic [31:0]    w_byp_sum;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_a_arr[g] = io_bus.req_a[32*g +: 32];
    assign w_b_arr[g] = io_bus.req_b[32*g +: 32];
  end

  // Round-robin search starting at r_ptr, wrapping at N.
  always_comb begin : arb
    logic [IDW:0] v_idx;
    v_idx    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < N; k++) begin
      v_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (v_idx >= (IDW+1)'(N)) v_idx = v_idx - (IDW+1)'(N);
      if (!w_found && io_bus.req_valid[v_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_idx[IDW-1:0];
      end
    end
    w_sel_a = w_a_arr[w_winner];
    w_sel_b = w_b_arr[w_winner];
  end

  assign w_accept   = (r_state == StIdle) && w_found;
  assign w_rsp_done = r_rsp_valid && io_bus.rsp_ready;

`ifdef FP_SCHED_ZERO_BYPASS_EN
  logic w_a_zero, w_b_zero;
  assign w_a_zero  = (w_sel_a[30:0] == 31'd0);
  assign w_b_zero  = (w_sel_b[30:0] == 31'd0);
  assign w_bypass  = w_a_zero || w_b_zero;
  // A zero (or both zero) returns B; only B zero returns A.
  assign w_byp_sum = w_a_zero ? w_sel_b : w_sel_a;
`else
  assign w_bypass  = 1'b0;
  assign w_byp_sum = w_sel_b;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = w_bypass ? StResp : StWait;
      StWait:  if (r_cnt == 4'd0) w_state_d = StResp;
      StResp:  if (w_rsp_done) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs. req_ready is masked during reset so it reads 0 even with requests pending.
  always_comb begin
    w_req_ready = '0;
    if ((r_state == StIdle) && w_found && i_rst_n) w_req_ready[w_winner] = 1'b1;
    o_busy = (r_state != StIdle);
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_rsp_id    <= '0;
      r_cnt       <= 4'd0;
      r_add_a     <= 32'd0;
      r_add_b     <= 32'd0;
      r_rsp_sum   <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_unf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_add_a  <= w_sel_a;
            r_add_b  <= w_sel_b;
            r_rsp_id <= w_winner;
            r_cnt    <= 4'(ADD_LAT - 1);
            if (w_bypass) begin
              r_rsp_sum   <= w_byp_sum;
              r_rsp_ovf   <= 1'b0;
              r_rsp_unf   <= 1'b0;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        StWait: begin
          if (r_cnt == 4'd0) begin
            r_rsp_sum   <= i_add_sum;
            r_rsp_ovf   <= i_add_ovf;
            r_rsp_unf   <= i_add_unf;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_rsp_id == IDW'(N - 1)) ? '0 : r_rsp_id + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_add_a          = r_add_a;
  assign o_add_b          = r_add_b;
  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_id    = r_rsp_id;
  assign io_bus.rsp_sum   = r_rsp_sum;
  assign io_bus.rsp_ovf   = r_rsp_ovf;
  assign io_bus.rsp_unf   = r_rsp_unf;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: a transaction-level model checks every output on every
// falling edge; directed scenarios add literal expectations for the headline cases.
module tb_fp_add_scheduler;
  localparam int unsigned N       = 2;
  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned IDW     = $clog2(N);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] add_a, add_b;
  logic [31:0] add_sum = 32'd0;
  logic        add_ovf = 1'b0;
  logic        add_unf = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_add_scheduler_if #(.N(N), .IDW(IDW)) bus ();

  fp_add_scheduler #(.N(N), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .io_bus   (bus),
    .o_add_a  (add_a),
    .o_add_b  (add_b),
    .i_add_sum(add_sum),
    .i_add_ovf(add_ovf),
    .i_add_unf(add_unf),
    .o_busy   (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference adder results {ovf, unf, sum} for the operand pairs the bench uses.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return {2'b00, 32'h40400000};
      {32'h40400000, 32'h40800000}: return {2'b00, 32'h40E00000};
      {32'h7F000000, 32'h7F000000}: return {2'b10, 32'h7F800000};
      {32'h00800000, 32'h80700000}: return {2'b01, 32'h00000000};
      {32'h80000000, 32'h40A00000}: return {2'b00, 32'h40A00000};
      default:                      return {2'b00, a + b};
    endcase
  endfunction

  // Adder stand-in: outputs junk until its inputs have been stable long enough.
  initial begin
    logic [31:0] last_a, last_b;
    int settle;
    last_a = 32'd0; last_b = 32'd0; settle = 0;
    forever begin
      @(posedge clk);
      #2;
      if (add_a !== last_a || add_b !== last_b) settle = 0;
      else settle++;
      last_a = add_a;
      last_b = add_b;
      if (settle >= int'(ADD_LAT) - 1) {add_ovf, add_unf, add_sum} = ref_add(add_a, add_b);
      else {add_ovf, add_unf, add_sum} = {1'b1, 1'b1, 32'hDEADBEEF};
    end
  end

  // Transaction-level model and per-cycle compare.
  int m_busy, m_age, m_lat, m_id, m_ptr;
  logic [31:0] m_add_a, m_add_b;
  logic [33:0] m_res;
  int id_log[$];
  int rsp_pulses = 0;

  initial begin
    int w, idx;
    logic [N-1:0] exp_ready;
    bit exp_rsp;
    logic [31:0] oa, ob;
    m_busy = 0; m_age = 0; m_lat = 0; m_id = 0; m_ptr = 0;
    m_add_a = 0; m_add_b = 0; m_res = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_age = 0; m_id = 0; m_ptr = 0; m_add_a = 0; m_add_b = 0;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_sum", bus.rsp_sum, 32'd0);
        continue;
      end
      exp_rsp = (m_busy != 0) && (m_age >= m_lat);
      w = -1;
      if (m_busy == 0) begin
        for (int j = 0; j < int'(N); j++) begin
          idx = (m_ptr + j) % int'(N);
          if (w < 0 && bus.req_valid[idx]) w = idx;
        end
      end
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_busy));
      check("add_a", add_a, m_add_a);
      check("add_b", add_b, m_add_b);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
      if (bus.rsp_valid) rsp_pulses++;
      if (exp_rsp) begin
        check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        check("rsp_sum", bus.rsp_sum, m_res[31:0]);
        check("rsp_ovf", 32'(bus.rsp_ovf), 32'(m_res[33]));
        check("rsp_unf", 32'(bus.rsp_unf), 32'(m_res[32]));
      end
      // Advance the model across the coming rising edge.
      if (m_busy == 0) begin
        if (w >= 0) begin
          oa = bus.req_a[32*w +: 32];
          ob = bus.req_b[32*w +: 32];
          m_busy = 1; m_id = w; m_age = 0; m_add_a = oa; m_add_b = ob;
          m_res = ref_add(oa, ob);
          m_lat = int'(ADD_LAT);
`ifdef FP_SCHED_ZERO_BYPASS_EN
          if (oa[30:0] == 31'd0) begin m_res = {2'b00, ob}; m_lat = 1; end
          else if (ob[30:0] == 31'd0) begin m_res = {2'b00, oa}; m_lat = 1; end
`endif
        end
      end else if (exp_rsp && bus.rsp_ready) begin
        m_busy = 0;
        m_ptr = (m_id + 1) % int'(N);
        id_log.push_back(m_id);
      end else begin
        m_age++;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one request and returns #1 after the accepting edge.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 0;
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
    bus.req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.req_ready[id]) ok = 1;
    end
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Counts edges until rsp_valid, then returns the payload.
  task automatic wait_rsp(output int lat, output logic [31:0] sum, output logic [31:0] id,
                          output logic ovf, output logic unf);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    sum = bus.rsp_sum;
    id  = 32'(bus.rsp_id);
    ovf = bus.rsp_ovf;
    unf = bus.rsp_unf;
  endtask

  initial begin
    int lat, n;
    logic [31:0] sum, id, hold_sum;
    logic ovf, unf;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    do_reset();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_add_b", add_b, 32'd0);

    // Single op.
    issue(0, 32'h3F800000, 32'h40000000);
    wait_rsp(lat, sum, id, ovf, unf);
    check("single_lat", 32'(lat), 32'd2);
    check("single_sum", sum, 32'h40400000);
    check("single_id", id, 32'd0);
    check("single_flags", {30'd0, ovf, unf}, 32'd0);

    // Flag capture.
    issue(0, 32'h7F000000, 32'h7F000000);
    wait_rsp(lat, sum, id, ovf, unf);
    check("ovf_sum", sum, 32'h7F800000);
    check("ovf_flags", {30'd0, ovf, unf}, 32'd2);
    issue(1, 32'h00800000, 32'h80700000);
    wait_rsp(lat, sum, id, ovf, unf);
    check("unf_id", id, 32'd1);
    check("unf_flags", {30'd0, ovf, unf}, 32'd1);

    // Zero operand.
    issue(0, 32'h80000000, 32'h40A00000);
    wait_rsp(lat, sum, id, ovf, unf);
    check("zero_sum", sum, 32'h40A00000);
    check("zero_flags", {30'd0, ovf, unf}, 32'd0);
`ifdef FP_SCHED_ZERO_BYPASS_EN
    check("zero_lat", 32'(lat), 32'd1);
`else
    check("zero_lat", 32'(lat), 32'(ADD_LAT));
`endif

    // Backpressure with a competing request pending.
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    issue(0, 32'h3F800000, 32'h40000000);
    bus.req_a[63:32] = 32'h40400000;
    bus.req_b[63:32] = 32'h40800000;
    bus.req_valid[1] = 1'b1;
    wait_rsp(lat, hold_sum, id, ovf, unf);
    check("bp_first_sum", hold_sum, 32'h40400000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check("bp_sum", bus.rsp_sum, hold_sum);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_done", 32'(busy), 32'd0);
    issue(1, 32'h40400000, 32'h40800000);
    wait_rsp(lat, sum, id, ovf, unf);
    check("bp_second_sum", sum, 32'h40E00000);
    check("bp_second_id", id, 32'd1);
    @(posedge clk);

    // Contention from reset.
    #1 rst_n = 1'b0;
    bus.req_a = {32'h40400000, 32'h3F800000};
    bus.req_b = {32'h40800000, 32'h40000000};
    bus.req_valid = 2'b11;
    id_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (id_log.size() < 3 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    bus.req_valid = '0;
    check("cont_count", 32'(id_log.size()), 32'd3);
    if (id_log.size() >= 3) begin
      check("cont_id0", 32'(id_log[0]), 32'd0);
      check("cont_id1", 32'(id_log[1]), 32'd1);
      check("cont_id2", 32'(id_log[2]), 32'd0);
    end
    n = 0;
    while ((busy || bus.rsp_valid) && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("cont_drain", 32'(busy), 32'd0);

    // Reset one cycle after the handshake.
    issue(1, 32'h3F800000, 32'h40000000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_add_a", add_a, 32'd0);
    check("midrst_sum", bus.rsp_sum, 32'd0);
    check("midrst_id", 32'(bus.rsp_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_pulses = 0;
    repeat (6) @(posedge clk);
    #1 check("midrst_no_rsp", 32'(rsp_pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
